// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type codes, type-field width, VC defaults, error bits
// and the per-VC packet framing step.
package noc_pkg;

  typedef logic [1:0] ftype_t;

  localparam ftype_t FLIT_HEAD     = 2'b10;
  localparam ftype_t FLIT_BODY     = 2'b00;
  localparam ftype_t FLIT_TAIL     = 2'b01;
  localparam ftype_t FLIT_HEADTAIL = 2'b11;

  // The type field occupies the top FTYPE_W bits of every flit.
  localparam int FTYPE_W  = 2;
  localparam int NVC_DEF  = 2;
  localparam int VCHW_DEF = 0;

  localparam int ERR_OVF = 0;
  localparam int ERR_FRM = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  // Returns {framing_error, next_state}; on a misplaced head the new flit starts the state.
  function automatic logic [1:0] frame_step(input logic [0:0] st, input ftype_t ft);
    logic       err;
    logic [0:0] nxt;
    err = 1'b0;
    nxt = st;
    case (ft)
      FLIT_HEAD: begin
        err = (st == ST_PKT);
        nxt = ST_PKT;
      end
      FLIT_HEADTAIL: begin
        err = (st == ST_PKT);
        nxt = ST_IDLE;
      end
      FLIT_BODY: err = (st == ST_IDLE);
      default: begin
        err = (st == ST_IDLE);
        nxt = ST_IDLE;
      end
    endcase
    return {err, nxt};
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO, show-ahead read (rdata is 0 when empty), 1-cycle write-to-read.
// Writes while full and reads while empty are ignored.
module vc_fifo #(
  parameter int DATAW = 63,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [DATAW:0]          wdata,
  input  logic                    rd,
  output logic [DATAW:0]          rdata,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATAW:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign w_push = wr && !full;
  assign w_pop  = rd && !empty;
  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign count  = r_count;
  assign rdata  = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/local_vc_ibuf.sv
// Local-port input buffer: per-VC FIFOs with framing check, 1-cycle write-to-read, show-ahead heads.
// ordy[v] comes from registered count only; a flit to a non-ready VC is dropped and flagged.
module local_vc_ibuf
  import noc_pkg::*;
#(
  parameter int DATAW = 63,
  parameter int NVC   = NVC_DEF,
  parameter int VCHW  = VCHW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [DATAW:0]            idata,
  input  logic                      ivalid,
  input  logic [VCHW:0]             ivch,
  output logic [NVC-1:0]            ordy,
  output logic [NVC*(DATAW+1)-1:0]  odata,
  output logic [NVC-1:0]            ovalid,
  input  logic [NVC-1:0]            ideq,
  output logic [NVC-1:0]            obusy,
  output logic [1:0]                oerr
);

  localparam int CW = $clog2(DEPTH) + 1;

  ftype_t         w_ftype;
  logic [NVC-1:0] w_wr;
  logic [NVC-1:0] w_full;
  logic [NVC-1:0] w_empty;
  logic [NVC-1:0] w_frm_err;
  logic [CW-1:0]  w_cnt [NVC];
  logic           w_ovf;
  logic [1:0]     r_err;

  assign w_ftype = idata[DATAW -: FTYPE_W];

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    logic [0:0] r_state;
    logic [1:0] w_step;

    // An out-of-range ivch matches no VC, so it falls through to the overflow path.
    assign w_wr[v] = ivalid && (ivch == (VCHW+1)'(v)) && !w_full[v];

    vc_fifo #(
      .DATAW (DATAW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst_),
      .wr    (w_wr[v]),
      .wdata (idata),
      .rd    (ideq[v]),
      .rdata (odata[v*(DATAW+1) +: DATAW+1]),
      .empty (w_empty[v]),
      .full  (w_full[v]),
      .count (w_cnt[v])
    );

    assign ordy[v]   = !rst_ && (w_cnt[v] != CW'(DEPTH));
    assign ovalid[v] = !w_empty[v];

    assign w_step       = frame_step(r_state, w_ftype);
    assign w_frm_err[v] = w_wr[v] && w_step[1];
    assign obusy[v]     = (r_state == ST_PKT);

    always_ff @(posedge clk or posedge rst_) begin
      if (rst_)         r_state <= ST_IDLE;
      else if (w_wr[v]) r_state <= w_step[0];
    end
  end

  assign w_ovf = ivalid && !(|w_wr);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_err <= '0;
    end else begin
      if (w_ovf)      r_err[ERR_OVF] <= 1'b1;
      if (|w_frm_err) r_err[ERR_FRM] <= 1'b1;
    end
  end

  assign oerr = r_err;

endmodule

// File: tb/tb_local_vc_ibuf.sv
// Scoreboard bench for local_vc_ibuf: directed scenarios then randomized traffic against a
// queue-based model; a negedge monitor compares heads and status against queued expectations.
module tb_local_vc_ibuf;
  import noc_pkg::*;

  localparam int DATAW = 63;
  localparam int NVC   = 2;
  localparam int VCHW  = 0;
  localparam int DEPTH = 4;

  logic                      clk = 1'b0;
  logic                      rst_;
  logic [DATAW:0]            idata;
  logic                      ivalid;
  logic [VCHW:0]             ivch;
  logic [NVC-1:0]            ordy;
  logic [NVC*(DATAW+1)-1:0]  odata;
  logic [NVC-1:0]            ovalid;
  logic [NVC-1:0]            ideq;
  logic [NVC-1:0]            obusy;
  logic [1:0]                oerr;

  always #5 clk = ~clk;

  local_vc_ibuf #(.DATAW(DATAW), .NVC(NVC), .VCHW(VCHW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .idata  (idata),
    .ivalid (ivalid),
    .ivch   (ivch),
    .ordy   (ordy),
    .odata  (odata),
    .ovalid (ovalid),
    .ideq   (ideq),
    .obusy  (obusy),
    .oerr   (oerr)
  );

  typedef struct {
    int         due;
    logic [1:0] rdy;
    logic [1:0] vld;
    logic [1:0] busy;
    logic [1:0] err;
  } st_t;

  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  st_t            st_q[$];
  logic [DATAW:0] exp_q [NVC][$];
  int             mc [NVC];
  bit             mopen [NVC];
  logic [1:0]     merr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NVC; v++) begin
      mc[v] = 0;
      mopen[v] = 1'b0;
      exp_q[v].delete();
    end
    merr = 2'b00;
    st_q.delete();
  endtask

  // Drives one cycle of stimulus, advances the model across the coming edge, queues expectations.
  task automatic step(input bit vin, input int vc, input logic [1:0] ft,
                      input logic [61:0] pay, input logic [1:0] dq);
    bit  acc;
    st_t s;
    ivalid = vin;
    ivch   = vc[VCHW:0];
    idata  = {ft, pay};
    ideq   = dq;
    acc = vin && (vc < NVC) && (mc[vc] < DEPTH);
    for (int v = 0; v < NVC; v++)
      if (dq[v] && mc[v] > 0) mc[v]--;
    if (acc) begin
      exp_q[vc].push_back({ft, pay});
      mc[vc]++;
      case (ft)
        FLIT_HEAD:     begin if (mopen[vc]) merr[1] = 1'b1; mopen[vc] = 1'b1; end
        FLIT_HEADTAIL: begin if (mopen[vc]) merr[1] = 1'b1; mopen[vc] = 1'b0; end
        FLIT_BODY:     begin if (!mopen[vc]) merr[1] = 1'b1; end
        default:       begin if (!mopen[vc]) merr[1] = 1'b1; mopen[vc] = 1'b0; end
      endcase
    end else if (vin) begin
      merr[0] = 1'b1;
    end
    s.due = cyc + 1;
    for (int v = 0; v < NVC; v++) begin
      s.rdy[v]  = (mc[v] < DEPTH);
      s.vld[v]  = (mc[v] > 0);
      s.busy[v] = mopen[v];
    end
    s.err = merr;
    st_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_   = 1'b1;
    ivalid = 1'b0;
    ideq   = '0;
    model_reset();
    #1;
    chk("rst_ordy", 64'(ordy), 64'(2'b00));
    chk("rst_ovalid", 64'(ovalid), 64'(2'b00));
    chk("rst_obusy", 64'(obusy), 64'(2'b00));
    chk("rst_oerr", 64'(oerr), 64'(2'b00));
    chk("rst_odata0", odata[63:0], 64'd0);
    chk("rst_odata1", odata[127:64], 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b0;
    #1;
    chk("rel_ordy", 64'(ordy), 64'(2'b11));
    chk("rel_ovalid", 64'(ovalid), 64'(2'b00));
    chk("rel_obusy", 64'(obusy), 64'(2'b00));
    chk("rel_oerr", 64'(oerr), 64'(2'b00));
  endtask

  // Monitor: status after each edge, and the head flit of every non-empty VC.
  initial begin : monitor
    st_t            s;
    logic [DATAW:0] slice;
    forever begin
      @(negedge clk);
      if (rst_ === 1'b0) begin
        while (st_q.size() > 0 && st_q[0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL stale_status actual=missed required=due%0d (cycle %0d)", st_q[0].due, cyc);
          void'(st_q.pop_front());
        end
        if (st_q.size() > 0 && st_q[0].due == cyc) begin
          s = st_q.pop_front();
          chk("ordy", 64'(ordy), 64'(s.rdy));
          chk("ovalid", 64'(ovalid), 64'(s.vld));
          chk("obusy", 64'(obusy), 64'(s.busy));
          chk("oerr", 64'(oerr), 64'(s.err));
        end
        for (int v = 0; v < NVC; v++) begin
          slice = odata[v*(DATAW+1) +: DATAW+1];
          if (ovalid[v]) begin
            if (exp_q[v].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL vc%0d_extra_flit actual=%h required=none", v, slice);
            end else begin
              chk($sformatf("vc%0d_head", v), slice, exp_q[v][0]);
              if (ideq[v]) void'(exp_q[v].pop_front());
            end
          end else begin
            chk($sformatf("vc%0d_empty_data", v), slice, 64'd0);
          end
        end
      end
    end
  end

  initial begin : driver
    bit         vin;
    int         vc;
    logic [1:0] ft;
    logic [1:0] dq;
    ivalid = 1'b0;
    ideq   = '0;
    idata  = '0;
    ivch   = '0;
    rst_   = 1'b0;
    #2;
    do_reset();

    // Single HEADTAIL on VC0, then dequeue it.
    step(1, 0, FLIT_HEADTAIL, 62'hA5, 2'b00);
    step(0, 0, FLIT_BODY, 62'h0, 2'b01);

    // Fill VC1, overflow, dequeue-while-full with refused write, then refill across wrap.
    for (int i = 0; i < 4; i++)
      step(1, 1, (i == 0) ? FLIT_HEAD : FLIT_BODY, 62'h100 + 62'(i), 2'b00);
    step(1, 1, FLIT_BODY, 62'h1FF, 2'b00);
    step(1, 1, FLIT_TAIL, 62'h1EE, 2'b10);
    step(1, 1, FLIT_TAIL, 62'h104, 2'b00);
    for (int i = 0; i < 5; i++)
      step(0, 0, FLIT_BODY, 62'h0, 2'b11);

    // Interleaved well-formed packets on both VCs.
    do_reset();
    step(1, 0, FLIT_HEAD, 62'h200, 2'b00);
    step(1, 1, FLIT_HEAD, 62'h300, 2'b00);
    step(1, 0, FLIT_BODY, 62'h201, 2'b00);
    step(1, 1, FLIT_BODY, 62'h301, 2'b00);
    step(1, 0, FLIT_TAIL, 62'h202, 2'b00);
    step(1, 1, FLIT_TAIL, 62'h302, 2'b00);
    for (int i = 0; i < 4; i++)
      step(0, 0, FLIT_BODY, 62'h0, 2'b11);

    // Framing errors, then reset with packets open on both VCs.
    step(1, 0, FLIT_BODY, 62'h400, 2'b00);
    step(1, 1, FLIT_HEAD, 62'h500, 2'b00);
    step(1, 1, FLIT_HEAD, 62'h501, 2'b00);
    step(1, 0, FLIT_HEAD, 62'h401, 2'b00);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      vin = ($urandom_range(0, 99) < 70);
      vc  = int'($urandom_range(0, NVC - 1));
      if ($urandom_range(0, 99) < 75)
        ft = mopen[vc] ? (($urandom_range(0, 1) == 0) ? FLIT_BODY : FLIT_TAIL)
                       : (($urandom_range(0, 1) == 0) ? FLIT_HEAD : FLIT_HEADTAIL);
      else
        ft = 2'($urandom_range(0, 3));
      dq[0] = ($urandom_range(0, 99) < 40);
      dq[1] = ($urandom_range(0, 99) < 40);
      step(vin, vc, ft, 62'({$urandom(), $urandom()}), dq);
    end

    ivalid = 1'b0;
    ideq   = '0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
